// File: rtl/spi_mem_pkg.sv
// Shared definitions for the burst SPI memory slave.
// Contents: FSM state enum and the R/W bit encodings used in the frame header.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_RW,
        WRITE_DATA,
        WRITE_COMMIT,
        READ_LOAD,
        READ_DATA,
        DONE
    } spi_state_e;

    localparam logic SPI_RW_READ  = 1'b1;
    localparam logic SPI_RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_input_conditioner.sv
// Synchroniser plus edge detector for one asynchronous SPI pin.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   pin        : raw asynchronous input
//   level      : pin after SYNC_STAGES flops
//   rise, fall : single-cycle pulses on synchronised level transitions
// The chain resets to 0 so that a pin already low at reset release
// produces no falling edge (a held-low chip select is not a new frame).
module spi_input_conditioner #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave giving an external master access to a DEPTH x DATA_W RAM.
// Frame: ADDR_W address bits, one R/W bit (1 = read), then data words,
// all MSB first. With BURST_EN the address auto-increments (mod DEPTH)
// for every further word in the frame.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   sclk_pin   : SPI clock (sampled, never used as a clock)
//   cs_pin     : chip select, active low
//   mosi_pin   : master-out data
//   miso_pin   : slave-out data, forced 0 whenever miso_oe is 0
//   miso_oe    : pad output enable, high in the read data phase
//   leds       : low 4 bits of the last committed write word (DATA_W >= 4)
module spi_memory_burst
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int BURST_EN    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic [3:0] leds
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi, mosi_rise, mosi_fall;
    logic unused_levels;

    spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .reset(reset), .pin(sclk_pin),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .reset(reset), .pin(cs_pin),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    // Only the synchronised level of mosi is used.
    spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .reset(reset), .pin(mosi_pin),
        .level(mosi), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_levels = &{1'b0, sclk_level, cs_level, mosi_rise, mosi_fall};

    spi_state_e        state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic              miso_q;
    logic              oe_q;
    logic [3:0]        leds_q;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (cs_rise) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:         if (cs_fall) state_n = GET_ADDR;
                GET_ADDR:     if (sclk_rise && bit_cnt == ADDR_LAST) state_n = GET_RW;
                GET_RW:       if (sclk_rise) state_n = (mosi == SPI_RW_WRITE) ? WRITE_DATA : READ_LOAD;
                WRITE_DATA:   if (sclk_rise && bit_cnt == DATA_LAST) state_n = WRITE_COMMIT;
                WRITE_COMMIT: state_n = (BURST_EN != 0) ? WRITE_DATA : DONE;
                READ_LOAD:    state_n = READ_DATA;
                READ_DATA:    if (sclk_fall && bit_cnt == DATA_LAST)
                                  state_n = (BURST_EN != 0) ? READ_LOAD : DONE;
                DONE:         state_n = DONE;
                default:      state_n = IDLE;
            endcase
        end
    end

    // DONE keeps miso/miso_oe as left by the last falling edge so the
    // master can still sample the final bit; cs high clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr    <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            leds_q  <= '0;
        end else if (cs_rise) begin
            bit_cnt <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    miso_q  <= 1'b0;
                    oe_q    <= 1'b0;
                end
                GET_ADDR: begin
                    if (sclk_rise) begin
                        addr    <= ADDR_W'({addr, mosi});
                        bit_cnt <= (bit_cnt == ADDR_LAST) ? '0 : bit_cnt + CNT_W'(1);
                    end
                end
                WRITE_DATA: begin
                    if (sclk_rise) begin
                        shift   <= DATA_W'({shift, mosi});
                        bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + CNT_W'(1);
                    end
                end
                WRITE_COMMIT: begin
                    leds_q <= shift[3:0];
                    addr   <= addr + ADDR_W'(1);
                end
                READ_LOAD: begin
                    shift   <= mem[addr];
                    addr    <= addr + ADDR_W'(1);
                    oe_q    <= 1'b1;
                    bit_cnt <= '0;
                end
                READ_DATA: begin
                    if (sclk_fall) begin
                        miso_q  <= shift[DATA_W-1];
                        shift   <= shift << 1;
                        bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == WRITE_COMMIT && !cs_rise) mem[addr] <= shift;
    end

    assign miso_pin = miso_q & oe_q;
    assign miso_oe  = oe_q;
    assign leds     = leds_q;

endmodule

// File: tb/tb_spi_memory_burst.sv
// Bench for spi_memory_burst: one burst-enabled and one single-word DUT
// share sclk/mosi with separate chip selects, so the deselected DUT sees
// clock and data activity while idle. A frame-level memory model predicts
// read data and leds; a per-cycle monitor checks the output pins.
module tb_spi_memory_burst;

    localparam int H = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       mosi;
    logic [1:0] cs;
    logic       miso0, miso1, oe0, oe1;
    logic [3:0] leds0, leds1;

    int total = 0;
    int bad   = 0;

    logic [7:0] mm [2][128];
    bit         mv [2][128];
    logic [3:0] ml [2];
    bit         settled [2];
    bit         in_read [2];
    logic [7:0] wq [$];
    logic [7:0] rq [$];

    always #5 clk = ~clk;

    spi_memory_burst #(.ADDR_W(7), .DATA_W(8), .BURST_EN(1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs[1]), .mosi_pin(mosi),
        .miso_pin(miso1), .miso_oe(oe1), .leds(leds1)
    );

    spi_memory_burst #(.ADDR_W(7), .DATA_W(8), .BURST_EN(0), .SYNC_STAGES(2)) u0 (
        .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs[0]), .mosi_pin(mosi),
        .miso_pin(miso0), .miso_oe(oe0), .leds(leds0)
    );

    function automatic logic get_miso(input int d);
        return (d == 1) ? miso1 : miso0;
    endfunction

    function automatic logic get_oe(input int d);
        return (d == 1) ? oe1 : oe0;
    endfunction

    function automatic logic [3:0] get_leds(input int d);
        return (d == 1) ? leds1 : leds0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One SPI mode-0 bit: data set while sclk low, miso sampled just before the rise.
    task automatic bitx(input int d, input logic b, output logic s);
        mosi = b;
        tick(H);
        s = get_miso(d);
        sclk = 1'b1;
        tick(H);
        sclk = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset == 1'b0) begin
            for (int d = 0; d < 2; d++) begin
                chk("miso_gated", (get_oe(d) == 1'b0) ? get_miso(d) : 1'b0, 32'd0);
                if (settled[d]) begin
                    chk("idle_oe", get_oe(d), 32'd0);
                    chk("idle_leds", get_leds(d), ml[d]);
                end
                if (in_read[d]) chk("read_oe", get_oe(d), 32'd1);
            end
        end
    end

    // cut >= 0: raise cs after that many data bits; rst_at >= 0: reset at that read bit.
    task automatic frame(input int d, input logic [6:0] a, input bit rd, input int nw,
                         input int cut, input int rst_at);
        int         nb;
        int         k;
        int         ncomp;
        logic [6:0] pa;
        logic [7:0] got;
        logic       s;
        rq.delete();
        settled[d] = 1'b0;
        cs[d] = 1'b0;
        tick(2 * H);
        for (int i = 6; i >= 0; i--) bitx(d, a[i], s);
        bitx(d, rd, s);
        nb  = (cut >= 0) ? cut : nw * 8;
        pa  = a;
        got = '0;
        for (int j = 0; j < nb; j++) begin
            k = j / 8;
            if (rd && j == rst_at) begin
                in_read[d] = 1'b0;
                reset = 1'b1;
                #1;
                chk("rst_miso", get_miso(d), 32'd0);
                chk("rst_oe", get_oe(d), 32'd0);
                chk("rst_leds0", leds0, 32'd0);
                chk("rst_leds1", leds1, 32'd0);
                ml[0] = '0;
                ml[1] = '0;
                cs[d] = 1'b1;
                tick(2);
                reset = 1'b0;
                tick(2 * H);
                settled[d] = 1'b1;
                return;
            end
            if (rd) begin
                in_read[d] = 1'b1;
                bitx(d, 1'($urandom_range(0, 1)), s);
                got[7 - (j % 8)] = s;
                if (j % 8 == 7) begin
                    rq.push_back(got);
                    if ((d == 1 || k == 0) && mv[d][pa]) chk("read_word", got, mm[d][pa]);
                    pa = pa + 7'd1;
                end
            end else begin
                bitx(d, wq[k][7 - (j % 8)], s);
            end
        end
        in_read[d] = 1'b0;
        tick(H);
        cs[d] = 1'b1;
        if (!rd) begin
            ncomp = nb / 8;
            if (d == 0 && ncomp > 1) ncomp = 1;
            for (int w = 0; w < ncomp; w++) begin
                mm[d][pa] = wq[w];
                mv[d][pa] = 1'b1;
                ml[d]     = wq[w][3:0];
                pa        = pa + 7'd1;
            end
        end
        tick(2 * H);
        settled[d] = 1'b1;
    endtask

    initial begin
        int         d;
        int         nw;
        int         cut;
        logic [6:0] a;
        bit         rd;

        reset = 1'b1;
        cs    = 2'b11;
        sclk  = 1'b0;
        mosi  = 1'b0;
        for (int x = 0; x < 2; x++) begin
            ml[x] = '0;
            settled[x] = 1'b0;
            in_read[x] = 1'b0;
            for (int i = 0; i < 128; i++) mv[x][i] = 1'b0;
        end
        tick(4);
        chk("reset_leds1", leds1, 32'd0);
        chk("reset_leds0", leds0, 32'd0);
        chk("reset_oe1", oe1, 32'd0);
        chk("reset_oe0", oe0, 32'd0);
        chk("reset_miso1", miso1, 32'd0);
        chk("reset_miso0", miso0, 32'd0);
        reset = 1'b0;
        tick(2 * H);
        settled[0] = 1'b1;
        settled[1] = 1'b1;

        // single write then read
        wq = '{8'hB1};
        frame(1, 7'h61, 1'b0, 1, -1, -1);
        frame(1, 7'h61, 1'b1, 1, -1, -1);
        chk("b1_read", rq[0], 32'hB1);
        chk("b1_leds", leds1, 32'h1);

        // burst write across the top of memory, burst read back
        wq = '{8'hAA, 8'h55, 8'h3C};
        frame(1, 7'h7E, 1'b0, 3, -1, -1);
        frame(1, 7'h7E, 1'b1, 3, -1, -1);
        chk("burst_rd0", rq[0], 32'hAA);
        chk("burst_rd1", rq[1], 32'h55);
        chk("burst_rd2", rq[2], 32'h3C);
        chk("burst_leds", leds1, 32'hC);
        frame(1, 7'h00, 1'b1, 1, -1, -1);
        chk("wrap_rd", rq[0], 32'h3C);

        // single-word device ignores the second word of a frame
        wq = '{8'h99};
        frame(0, 7'h11, 1'b0, 1, -1, -1);
        wq = '{8'h12, 8'h34};
        frame(0, 7'h10, 1'b0, 2, -1, -1);
        frame(0, 7'h10, 1'b1, 1, -1, -1);
        chk("nb_rd10", rq[0], 32'h12);
        frame(0, 7'h11, 1'b1, 1, -1, -1);
        chk("nb_rd11", rq[0], 32'h99);
        chk("nb_leds", leds0, 32'h2);

        // partial word is discarded
        wq = '{8'h66};
        frame(1, 7'h05, 1'b0, 1, -1, -1);
        wq = '{8'h77};
        frame(1, 7'h05, 1'b0, 1, 5, -1);
        chk("partial_leds", leds1, 32'h6);
        frame(1, 7'h05, 1'b1, 1, -1, -1);
        chk("partial_rd", rq[0], 32'h66);

        // reset in the middle of a read, then a normal frame pair
        frame(1, 7'h7E, 1'b1, 1, -1, 3);
        chk("post_rst_leds", leds1, 32'h0);
        wq = '{8'h7E};
        frame(1, 7'h22, 1'b0, 1, -1, -1);
        frame(1, 7'h22, 1'b1, 1, -1, -1);
        chk("post_rst_rd", rq[0], 32'h7E);
        chk("post_rst_wleds", leds1, 32'hE);

        // randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            d  = $urandom_range(0, 1);
            a  = 7'($urandom);
            rd = 1'($urandom_range(0, 1));
            if (rd) nw = (d == 1) ? $urandom_range(1, 3) : 1;
            else    nw = $urandom_range(1, (d == 1) ? 3 : 2);
            wq.delete();
            for (int w = 0; w < nw; w++) wq.push_back(8'($urandom));
            cut = (!rd && $urandom_range(0, 5) == 0) ? $urandom_range(1, nw * 8 - 1) : -1;
            frame(d, a, rd, nw, cut, -1);
        end

        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
